// File: rtl/uctl_pkt_fifo.sv
// Synchronous FIFO for USB endpoint data with packet commit/discard.
// Pending words stay hidden from the reader until the packet is committed.
module uctl_pkt_fifo #(
    parameter int ADD_WIDTH     = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int NEAR_FULL_TH  = 2,
    parameter int NEAR_EMPTY_TH = 2,
    parameter int PKT_MODE      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sw_rst,
    input  logic                  wrEn,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  wrCommit,
    input  logic                  wrDiscard,
    input  logic                  rdEn,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  full,
    output logic                  nearly_full,
    output logic                  empty,
    output logic                  nearly_empty,
    output logic [ADD_WIDTH:0]    numOfData,
    output logic [ADD_WIDTH:0]    numOfPend,
    output logic [ADD_WIDTH:0]    numOfFreeLocs,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW    = ADD_WIDTH + 1;
    localparam int DEPTH = 1 << ADD_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] cm_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_nxt;
    logic [PW-1:0] used;
    logic          wr_acc;
    logic          rd_acc;

    // Pointer differences wrap mod 2**PW, so the extra MSB resolves full vs empty.
    assign used          = wr_ptr - rd_ptr;
    assign numOfData     = cm_ptr - rd_ptr;
    assign numOfPend     = wr_ptr - cm_ptr;
    assign numOfFreeLocs = PW'(DEPTH) - used;

    assign full         = (used == PW'(DEPTH));
    assign empty        = (cm_ptr == rd_ptr);
    assign nearly_full  = (32'(numOfFreeLocs) <= 32'(NEAR_FULL_TH));
    assign nearly_empty = (32'(numOfData) <= 32'(NEAR_EMPTY_TH));

    assign wr_acc = wrEn && !full;
    assign rd_acc = rdEn && !empty;
    assign wr_nxt = wr_ptr + PW'(wr_acc);

    assign dataOut = mem[rd_ptr[ADD_WIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (wr_acc && !sw_rst) begin
            mem[wr_ptr[ADD_WIDTH-1:0]] <= dataIn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            cm_ptr    <= '0;
            wr_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (sw_rst) begin
            rd_ptr    <= '0;
            cm_ptr    <= '0;
            wr_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wrEn && full) begin
                overflow <= 1'b1;
            end
            if (rdEn && empty) begin
                underflow <= 1'b1;
            end
            // Discard beats commit; a write accepted this cycle is rolled back too.
            unique case (1'b1)
                (PKT_MODE == 0): begin
                    wr_ptr <= wr_nxt;
                    cm_ptr <= wr_nxt;
                end
                wrDiscard: begin
                    wr_ptr <= cm_ptr;
                end
                default: begin
                    wr_ptr <= wr_nxt;
                    if (wrCommit) begin
                        cm_ptr <= wr_nxt;
                    end
                end
            endcase
        end
    end

endmodule
